// File: rtl/hb_pkg.sv
// Shared definitions for the heartbeat monitor: verdict encoding and default limits.
package hb_pkg;

  typedef enum logic [1:0] {
    StUnknown = 2'b00,
    StAlive   = 2'b01,
    StDead    = 2'b10
  } hb_state_e;

  localparam int unsigned DEF_CNT_W      = 24;
  localparam int unsigned DEF_MIN_PERIOD = 90000;
  localparam int unsigned DEF_MAX_PERIOD = 110000;
  localparam int unsigned DEF_GOOD_N     = 4;
  localparam int unsigned DEF_BAD_N      = 2;

endpackage

// File: rtl/heartbeat_monitor_if.sv
// Heartbeat pin, re-qualify request and verdict outputs of one monitor instance.
interface heartbeat_monitor_if
  import hb_pkg::*;
#(
  parameter int unsigned CNT_W = DEF_CNT_W
);

  logic             pwm;
  logic             clear;
  logic             edge_pulse;
  logic [CNT_W-1:0] period;
  logic             alive;
  logic             fault;
  hb_state_e        state;

  modport master (
    output pwm,
    output clear,
    input  edge_pulse,
    input  period,
    input  alive,
    input  fault,
    input  state
  );

  modport slave (
    input  pwm,
    input  clear,
    output edge_pulse,
    output period,
    output alive,
    output fault,
    output state
  );

endinterface

// File: rtl/pwm_sync_edge.sv
// Two-flop synchroniser with a history flop and a registered rising-edge pulse.
module pwm_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic edge_pulse
);

  logic s1, s2, s3;

  // Synchronise the pin and flag one cycle per rising edge
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1         <= 1'b0;
      s2         <= 1'b0;
      s3         <= 1'b0;
      edge_pulse <= 1'b0;
    end else begin
      s1         <= pin;
      s2         <= s1;
      s3         <= s2;
      edge_pulse <= s2 & ~s3;
    end
  end

endmodule

// File: rtl/heartbeat_monitor.sv
// Measures heartbeat rising-edge spacing and debounces an alive/fault verdict.
module heartbeat_monitor
  import hb_pkg::*;
#(
  parameter int unsigned CNT_W      = DEF_CNT_W,
  parameter int unsigned MIN_PERIOD = DEF_MIN_PERIOD,
  parameter int unsigned MAX_PERIOD = DEF_MAX_PERIOD,
  parameter int unsigned GOOD_N     = DEF_GOOD_N,
  parameter int unsigned BAD_N      = DEF_BAD_N
) (
  input logic               clk,
  input logic               rst_n,
  heartbeat_monitor_if.slave bus
);

  localparam int unsigned GOOD_W = $clog2(GOOD_N + 1);
  localparam int unsigned BAD_W  = $clog2(BAD_N + 1);

  logic              edge_pulse;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  period_q, period_d;
  logic              armed_q, armed_d;
  logic [GOOD_W-1:0] good_q, good_d;
  logic [BAD_W-1:0]  bad_q, bad_d;
  hb_state_e         state_q, state_d;
  logic              good_ev, bad_ev;

  pwm_sync_edge u_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .pin        (bus.pwm),
    .edge_pulse (edge_pulse)
  );

  // State register for counter, classifier, streaks and verdict
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      period_q <= '0;
      armed_q  <= 1'b0;
      good_q   <= '0;
      bad_q    <= '0;
      state_q  <= StUnknown;
    end else begin
      cnt_q    <= cnt_d;
      period_q <= period_d;
      armed_q  <= armed_d;
      good_q   <= good_d;
      bad_q    <= bad_d;
      state_q  <= state_d;
    end
  end

  // Period measurement, event classification, streak update and verdict FSM
  always_comb begin
    cnt_d    = cnt_q;
    period_d = period_q;
    armed_d  = armed_q;
    good_d   = good_q;
    bad_d    = bad_q;
    state_d  = state_q;
    good_ev  = 1'b0;
    bad_ev   = 1'b0;

    if (edge_pulse) begin
      cnt_d   = CNT_W'(1);
      armed_d = 1'b1;
      // The first edge after arming is lost only establishes a reference point
      if (armed_q) begin
        period_d = cnt_q;
        if (cnt_q >= CNT_W'(MIN_PERIOD)) good_ev = 1'b1;
        else                             bad_ev  = 1'b1;
      end
    end else if (cnt_q == CNT_W'(MAX_PERIOD)) begin
      if (armed_q) begin
        bad_ev  = 1'b1;
        armed_d = 1'b0;
        cnt_d   = CNT_W'(1);
      end else if (state_q != StDead) begin
        // Keep firing while unarmed so a dead CPU always ends up in DEAD
        bad_ev = 1'b1;
        cnt_d  = CNT_W'(1);
      end
    end else begin
      cnt_d = cnt_q + 1'b1;
    end

    if (good_ev) begin
      bad_d = '0;
      if (good_q != GOOD_W'(GOOD_N)) good_d = good_q + 1'b1;
    end
    if (bad_ev) begin
      good_d = '0;
      if (bad_q != BAD_W'(BAD_N)) bad_d = bad_q + 1'b1;
    end

    unique case (state_q)
      StUnknown: begin
        if (good_d == GOOD_W'(GOOD_N))    state_d = StAlive;
        else if (bad_d == BAD_W'(BAD_N))  state_d = StDead;
      end
      StAlive: if (bad_d == BAD_W'(BAD_N))    state_d = StDead;
      StDead:  if (good_d == GOOD_W'(GOOD_N)) state_d = StAlive;
      default: state_d = StUnknown;
    endcase

    if (state_d != state_q) begin
      good_d = '0;
      bad_d  = '0;
    end

    if (bus.clear) begin
      state_d  = StUnknown;
      armed_d  = 1'b0;
      cnt_d    = '0;
      good_d   = '0;
      bad_d    = '0;
      period_d = '0;
    end
  end

  assign bus.edge_pulse = edge_pulse;
  assign bus.period     = period_q;
  assign bus.state      = state_q;
  assign bus.alive      = (state_q == StAlive);
  assign bus.fault      = (state_q == StDead);

endmodule

// File: tb/tb_heartbeat_monitor.sv
// Directed bench for heartbeat_monitor with a small pwm pattern generator.
module tb_heartbeat_monitor;
  import hb_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  // Pattern generator controls: period 0 means hold force_level
  int   gen_period = 0;
  int   gen_alt = 0;
  bit   use_alt = 1'b0;
  logic force_level = 1'b0;

  heartbeat_monitor_if #(.CNT_W(16)) bus ();

  heartbeat_monitor #(
    .CNT_W      (16),
    .MIN_PERIOD (90),
    .MAX_PERIOD (110),
    .GOOD_N     (3),
    .BAD_N      (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wait_edge(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.edge_pulse && n < 300);
    check({tag, "_seen"}, 32'(bus.edge_pulse), 1);
  endtask

  // Square wave: high for half the period, new period picked at each rise
  initial begin
    int ph = 0;
    int cur = 0;
    bit flip = 1'b0;
    bus.pwm = 1'b0;
    forever begin
      @(negedge clk);
      if (gen_period != 0) begin
        if (ph == 0) begin
          cur  = (use_alt && flip) ? gen_alt : gen_period;
          flip = !flip;
        end
        bus.pwm = (ph < cur / 2);
        ph = (ph + 1 == cur) ? 0 : ph + 1;
      end else begin
        ph = 0;
        bus.pwm = force_level;
      end
    end
  end

  initial begin
    bus.clear = 1'b0;

    // Reset with a toggling pin, then the first cycle after release
    for (int i = 0; i < 5; i++) begin
      force_level = (i == 0 || i == 2);
      @(negedge clk);
      check("rst_outs", {11'd0, bus.edge_pulse, bus.alive, bus.fault, bus.state, bus.period}, 0);
    end
    rst_n = 1'b1;
    gen_period = 100;
    @(negedge clk);
    check("rel_outs", {11'd0, bus.edge_pulse, bus.alive, bus.fault, bus.state, bus.period}, 0);

    // Good heartbeat: first edge arms, ALIVE one cycle after the 4th edge
    wait_edge("g1");
    @(negedge clk);
    check("g1_period", 32'(bus.period), 0);
    check("g1_state", 32'(bus.state), StUnknown);
    wait_edge("g2");
    @(negedge clk);
    check("g2_period", 32'(bus.period), 100);
    wait_edge("g3");
    @(negedge clk);
    check("g3_state", 32'(bus.state), StUnknown);
    wait_edge("g4");
    check("g4_alive_early", 32'(bus.alive), 0);
    @(negedge clk);
    check("g4_alive", 32'(bus.alive), 1);
    check("g4_state", 32'(bus.state), StAlive);
    check("g4_period", 32'(bus.period), 100);

    // Stuck low: bad events at +110 and +220 after the last edge
    force_level = 1'b0;
    gen_period = 0;
    repeat (110) @(negedge clk);
    check("stuck_mid_alive", 32'(bus.alive), 1);
    repeat (109) @(negedge clk);
    check("stuck_pre_alive", 32'(bus.alive), 1);
    @(negedge clk);
    check("stuck_fault", 32'(bus.fault), 1);
    check("stuck_alive", 32'(bus.alive), 0);
    check("stuck_state", 32'(bus.state), StDead);

    // Recover from DEAD, then fast glitching at period 50
    gen_period = 100;
    wait_edge("r1");
    wait_edge("r2");
    wait_edge("r3");
    @(negedge clk);
    check("r3_fault", 32'(bus.fault), 1);
    wait_edge("r4");
    @(negedge clk);
    check("r4_state", 32'(bus.state), StAlive);
    gen_period = 50;
    wait_edge("f0");
    @(negedge clk);
    check("f0_period", 32'(bus.period), 100);
    wait_edge("f1");
    @(negedge clk);
    check("f1_period", 32'(bus.period), 50);
    check("f1_state", 32'(bus.state), StAlive);
    wait_edge("f2");
    @(negedge clk);
    check("f2_state", 32'(bus.state), StDead);
    check("f2_period", 32'(bus.period), 50);

    // Alternating 100/60 after a clear never leaves UNKNOWN
    gen_alt = 60;
    use_alt = 1'b1;
    gen_period = 100;
    wait_edge("a_pre1");
    wait_edge("a_pre2");
    @(negedge clk);
    bus.clear = 1'b1;
    @(negedge clk);
    bus.clear = 1'b0;
    check("a_clr_state", 32'(bus.state), StUnknown);
    check("a_clr_period", 32'(bus.period), 0);
    for (int i = 0; i < 8; i++) begin
      wait_edge("a");
      @(negedge clk);
      check("a_state", 32'(bus.state), StUnknown);
      if (i == 0) check("a_arm_period", 32'(bus.period), 0);
      else check("a_period_ok", 32'(bus.period == 100 || bus.period == 60), 1);
    end

    // Clear coincident with an edge while ALIVE
    use_alt = 1'b0;
    for (int i = 0; i < 5; i++) wait_edge("c_pre");
    @(negedge clk);
    check("c_pre_alive", 32'(bus.alive), 1);
    wait_edge("c_edge");
    bus.clear = 1'b1;
    @(negedge clk);
    bus.clear = 1'b0;
    check("c_state", 32'(bus.state), StUnknown);
    check("c_period", 32'(bus.period), 0);
    check("c_alive", 32'(bus.alive), 0);
    wait_edge("c_arm");
    @(negedge clk);
    check("c_arm_period", 32'(bus.period), 0);
    check("c_arm_state", 32'(bus.state), StUnknown);
    wait_edge("c1");
    @(negedge clk);
    check("c1_period", 32'(bus.period), 100);
    check("c1_state", 32'(bus.state), StUnknown);
    wait_edge("c2");
    @(negedge clk);
    check("c2_state", 32'(bus.state), StUnknown);
    wait_edge("c3");
    @(negedge clk);
    check("c3_state", 32'(bus.state), StAlive);
    check("c3_period", 32'(bus.period), 100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/heartbeat_monitor.md
# heartbeat_monitor

Qualifies the heartbeat square wave from one redundant CPU and produces a debounced alive/fault verdict for the `core` switchover logic. The block synchronises the pin, measures the period between rising edges and checks each period against a window. It requires several consecutive good or bad periods before changing its verdict. One instance sits on each CPU heartbeat pin, A and B, directly upstream of `core`.

## Interface
- `CNT_W`, 24: period counter width.
- `MIN_PERIOD`, 90000: shortest acceptable period, in clk cycles.
- `MAX_PERIOD`, 110000: longest acceptable period, in clk cycles. Must satisfy `MIN_PERIOD` ≤ `MAX_PERIOD` < 2^`CNT_W`.
- `GOOD_N`, 4: consecutive good events needed to enter ALIVE.
- `BAD_N`, 2: consecutive bad events needed to enter DEAD.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  synchronous, active-low reset.
- `pwm`  in  1  asynchronous heartbeat pin from the CPU.
- `clear`  in  1  synchronous re-qualify request from command logic; one-cycle pulse.
- `edge_pulse`  out  1  one cycle per qualified rising edge.
- `period`  out  `CNT_W`  last measured period, in cycles.
- `alive`  out  1  high in ALIVE.
- `fault`  out  1  high in DEAD.
- `state`  out  2  FSM state, for LEDs and status reporting.

## Operation
- **Synchroniser.** Two flops `s1`, `s2`, plus history flop `s3`. `edge_pulse` is registered `s2 & ~s3`.
- **Counter.** `cnt` counts cycles since the last edge.
  - On `edge_pulse`, `cnt <= 1`.
  - Otherwise it increments.
- **Arming.** `armed` is cleared by reset, by `clear` and by a timeout. An edge while unarmed only sets `armed`; it does not classify and does not update `period`.
- **Classification** of an edge while armed:
  - `period <= cnt`.
  - Good if `MIN_PERIOD` ≤ `cnt` ≤ `MAX_PERIOD`.
  - Bad if `cnt` < `MIN_PERIOD`.
- **Timeout.** If `cnt == MAX_PERIOD`, armed is set and there is no edge, a bad event fires, `armed <= 0` and `cnt <= 1`.
  - While unarmed, `cnt` saturates at `MAX_PERIOD`.
  - A stuck pin therefore yields one bad event every `MAX_PERIOD` cycles once re-armed. While unarmed and stuck, it yields no further events.
  - Exception: in UNKNOWN or ALIVE, an unarmed stuck pin still raises a bad event every `MAX_PERIOD` cycles, so that DEAD is always reached.
- **Streak counters.** `good_cnt` and `bad_cnt` each saturate at their threshold.
  - A good event increments `good_cnt` and zeroes `bad_cnt`.
  - A bad event does the reverse.
- **FSM.** Encoding: UNKNOWN = 00, ALIVE = 01, DEAD = 10.
  - UNKNOWN → ALIVE when `good_cnt` reaches `GOOD_N`.
  - UNKNOWN → DEAD when `bad_cnt` reaches `BAD_N`.
  - ALIVE → DEAD when `bad_cnt` reaches `BAD_N`.
  - DEAD → ALIVE when `good_cnt` reaches `GOOD_N`.
  - On a state change, both streak counters zero.
- **Outputs.** `alive = (state == ALIVE)`, `fault = (state == DEAD)`.
- **`clear`.**
  - Forces UNKNOWN, `armed = 0`, `cnt = 0`, streak counters 0 and `period = 0`.
  - Synchroniser flops are kept.
  - `clear` wins over a simultaneous edge or timeout.
- **Reset values.** All flops and all outputs are 0; `state` is UNKNOWN.

## Timing
- A `pwm` rise first sampled high at edge t gives `s2` = 1 after t+1 and `edge_pulse` high in the cycle after edge t+2.
- `period`, the streak counters, `state`, `alive` and `fault` update on the clock that ends the `edge_pulse` cycle. They are visible one cycle after `edge_pulse`.
- Timeout events have the same one-cycle latency, counted from the `cnt == MAX_PERIOD` cycle.
- Total latency is pin → verdict = 4 cycles after the deciding edge.
- High-time and duty cycle are ignored; only rising-edge spacing matters.

## Structure
- **Shared package `hb_pkg`** holds:
  - the state encoding constants;
  - the default `MIN_PERIOD`, `MAX_PERIOD`, `GOOD_N` and `BAD_N` values.
- **Sub-module `pwm_sync_edge`:** 2-flop synchroniser plus rising-edge detector, outputs `edge_pulse`. It is reusable for the mode pins.
- The counter, classifier and FSM stay in the top module.

## Test plan
Bench parameters: `CNT_W`=16, `MIN_PERIOD`=90, `MAX_PERIOD`=110, `GOOD_N`=3, `BAD_N`=2.

1. **Reset.** Hold `rst_n`=0 for 5 cycles with `pwm` toggling. Required: all outputs 0 and `state`=00 throughout, and for the first cycle after release.
2. **Good heartbeat.** Drive a 100-cycle square wave. Required:
   - the first edge arms only;
   - `alive`=1 one cycle after the 4th `edge_pulse`;
   - `period`=100.
3. **Stuck pin.** From ALIVE, hold `pwm` low. Required:
   - first bad event 110 cycles after the last edge;
   - `fault`=1 and `alive`=0 once the second bad event is registered.
4. **Fast glitching.** From ALIVE, drive a period of 50. Required:
   - `period`=50;
   - DEAD after two classified edges.
5. **Alternating periods.** In UNKNOWN, alternate periods 100 and 60. Required: `state` stays 00 indefinitely.
6. **Clear with coincident edge.** In ALIVE, pulse `clear` in the same cycle as `edge_pulse`. Required:
   - `state`=00 and `period`=0 next cycle;
   - the following edge only re-arms;
   - ALIVE again after 3 further good periods.
